// File: rtl/clic_arb_pkg.sv
// Shared types and helpers for the sequential CLIC priority arbiter.
// Candidate widths are fixed here; the arbiter geometry defaults to these values.
package clic_arb_pkg;

    localparam int unsigned DefNumSrc    = 256;
    localparam int unsigned DefSrcPerCyc = 32;
    localparam int unsigned CandLvlW     = 8;
    localparam int unsigned CandIdW      = $clog2(DefNumSrc);

    typedef enum logic [0:0] {
        SCAN = 1'b0,
        HOLD = 1'b1
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [CandIdW-1:0]  id;
        logic [CandLvlW-1:0] lvl;
    } cand_t;

    // True when a should win over b: any valid beats invalid, higher level wins, tie to lower id.
    function automatic logic cand_better(input cand_t a, input cand_t b);
        if (!a.valid) return 1'b0;
        if (!b.valid) return 1'b1;
        if (a.lvl != b.lvl) return a.lvl > b.lvl;
        return a.id < b.id;
    endfunction

endpackage

// File: rtl/clic_arb_chunk_max.sv
// Combinational max-finder over one chunk of sources.
// Heap-ordered balanced tree: node i has children 2i+1 and 2i+2, leaves hold the sources.
module clic_arb_chunk_max
    import clic_arb_pkg::*;
#(
    parameter int unsigned SrcPerCyc = DefSrcPerCyc,
    parameter int unsigned LvlWidth  = CandLvlW
) (
    input  logic [SrcPerCyc-1:0]               ip,
    input  logic [SrcPerCyc-1:0]               ie,
    input  logic [SrcPerCyc-1:0][LvlWidth-1:0] lvl,
    input  logic [LvlWidth-1:0]                thresh,
    input  logic [CandIdW-1:0]                 base,
    output cand_t                              best
);

    cand_t node [2*SrcPerCyc-1];

    for (genvar j = 0; j < SrcPerCyc; j++) begin : g_leaf
        assign node[SrcPerCyc-1+j].valid = ip[j] & ie[j] & (lvl[j] > thresh);
        assign node[SrcPerCyc-1+j].id    = base + CandIdW'(j);
        assign node[SrcPerCyc-1+j].lvl   = lvl[j];
    end

    for (genvar i = 0; i < SrcPerCyc - 1; i++) begin : g_node
        assign node[i] = cand_better(node[2*i+2], node[2*i+1]) ? node[2*i+2] : node[2*i+1];
    end

    assign best = node[0];

endmodule

// File: rtl/clic_irq_arbiter.sv
// Sequential CLIC arbiter: sweeps sources chunk by chunk, then offers the winner
// to the core through a valid/ready claim and pulses an edge-pending clear on claim.
module clic_irq_arbiter
    import clic_arb_pkg::*;
#(
    parameter int unsigned NumSrc    = DefNumSrc,
    parameter int unsigned LvlWidth  = CandLvlW,
    parameter int unsigned SrcPerCyc = DefSrcPerCyc
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumSrc-1:0]          ip_i,
    input  logic [NumSrc-1:0]          ie_i,
    input  logic [NumSrc-1:0]          edge_i,
    input  logic [NumSrc*LvlWidth-1:0] lvl_i,
    input  logic [LvlWidth-1:0]        thresh_i,
    output logic                       irq_valid_o,
    output logic [$clog2(NumSrc)-1:0]  irq_id_o,
    output logic [LvlWidth-1:0]        irq_lvl_o,
    input  logic                       irq_ready_i,
    output logic                       clr_valid_o,
    output logic [$clog2(NumSrc)-1:0]  clr_id_o
);

    localparam int unsigned Sweeps = NumSrc / SrcPerCyc;
    localparam int unsigned ChunkW = (Sweeps > 1) ? $clog2(Sweeps) : 1;
    localparam logic [ChunkW-1:0] LastChunk = ChunkW'(Sweeps - 1);

    state_e             state_q;
    logic [ChunkW-1:0]  chunk_q;
    cand_t              best_q;
    cand_t              hold_q;
    logic               clr_valid_q;
    logic [CandIdW-1:0] clr_id_q;

    logic [SrcPerCyc-1:0]               chunk_ip;
    logic [SrcPerCyc-1:0]               chunk_ie;
    logic [SrcPerCyc-1:0][LvlWidth-1:0] chunk_lvl;
    logic [CandIdW-1:0]                 chunk_base;
    cand_t                              chunk_best;
    cand_t                              run_best;
    cand_t                              next_best;
    logic                               held_drop;

    assign chunk_ip   = ip_i[chunk_q*SrcPerCyc +: SrcPerCyc];
    assign chunk_ie   = ie_i[chunk_q*SrcPerCyc +: SrcPerCyc];
    assign chunk_lvl  = lvl_i[chunk_q*(SrcPerCyc*LvlWidth) +: SrcPerCyc*LvlWidth];
    assign chunk_base = CandIdW'(chunk_q * SrcPerCyc);

    clic_arb_chunk_max #(
        .SrcPerCyc (SrcPerCyc),
        .LvlWidth  (LvlWidth)
    ) u_chunk_max (
        .ip     (chunk_ip),
        .ie     (chunk_ie),
        .lvl    (chunk_lvl),
        .thresh (thresh_i),
        .base   (chunk_base),
        .best   (chunk_best)
    );

    // The running best is discarded at chunk 0 so every sweep starts from scratch.
    assign run_best  = (chunk_q == '0) ? '0 : best_q;
    assign next_best = cand_better(chunk_best, run_best) ? chunk_best : run_best;

    assign held_drop = !ip_i[hold_q.id] || !ie_i[hold_q.id] || (thresh_i >= hold_q.lvl);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= SCAN;
            chunk_q     <= '0;
            best_q      <= '0;
            hold_q      <= '0;
            clr_valid_q <= 1'b0;
            clr_id_q    <= '0;
        end else begin
            clr_valid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    best_q <= next_best;
                    if (chunk_q == LastChunk) begin
                        chunk_q <= '0;
                        if (next_best.valid) begin
                            state_q <= HOLD;
                            hold_q  <= next_best;
                        end
                    end else begin
                        chunk_q <= chunk_q + 1'b1;
                    end
                end
                HOLD: begin
                    // A claim takes precedence over any retraction seen in the same cycle.
                    if (irq_ready_i) begin
                        clr_valid_q <= edge_i[hold_q.id];
                        clr_id_q    <= hold_q.id;
                        state_q     <= SCAN;
                        chunk_q     <= '0;
                    end else if (held_drop) begin
                        state_q <= SCAN;
                        chunk_q <= '0;
                    end
                end
                default: begin
                    state_q <= SCAN;
                    chunk_q <= '0;
                end
            endcase
        end
    end

    assign irq_valid_o = (state_q == HOLD);
    assign irq_id_o    = irq_valid_o ? hold_q.id  : '0;
    assign irq_lvl_o   = irq_valid_o ? hold_q.lvl : '0;
    assign clr_valid_o = clr_valid_q;
    assign clr_id_o    = clr_valid_q ? clr_id_q : '0;

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// Directed bench for clic_irq_arbiter: one task per scenario, inline expected values.
module tb_clic_irq_arbiter;

    localparam int NumSrc   = 256;
    localparam int LvlWidth = 8;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [NumSrc-1:0]          ip = '0;
    logic [NumSrc-1:0]          ie = '0;
    logic [NumSrc-1:0]          edge_t = '0;
    logic [NumSrc*LvlWidth-1:0] lvl = '0;
    logic [LvlWidth-1:0]        thresh = '0;
    logic                       irq_valid;
    logic [7:0]                 irq_id;
    logic [LvlWidth-1:0]        irq_lvl;
    logic                       irq_ready = 1'b0;
    logic                       clr_valid;
    logic [7:0]                 clr_id;

    int checks = 0;
    int errors = 0;

    clic_irq_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ip_i        (ip),
        .ie_i        (ie),
        .edge_i      (edge_t),
        .lvl_i       (lvl),
        .thresh_i    (thresh),
        .irq_valid_o (irq_valid),
        .irq_id_o    (irq_id),
        .irq_lvl_o   (irq_lvl),
        .irq_ready_i (irq_ready),
        .clr_valid_o (clr_valid),
        .clr_id_o    (clr_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ip = '0; ie = '0; edge_t = '0; lvl = '0; thresh = '0; irq_ready = 1'b0;
    endtask

    // Reset released right after an edge, so the next edge scans chunk 0.
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic set_src(input int k, input logic [LvlWidth-1:0] l, input logic e);
        ip[k] = 1'b1;
        ie[k] = 1'b1;
        edge_t[k] = e;
        lvl[k*LvlWidth +: LvlWidth] = l;
    endtask

    task automatic wait_offer(input int max_cyc, output int cyc, output bit got);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < max_cyc) begin
            step();
            cyc++;
            if (irq_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", irq_valid); end
        checks++; if (irq_id !== 8'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", irq_id); end
        checks++; if (irq_lvl !== 8'd0) begin errors++; $display("FAIL reset_lvl: got %0d expected 0", irq_lvl); end
        checks++; if (clr_valid !== 1'b0) begin errors++; $display("FAIL reset_clr_valid: got %b expected 0", clr_valid); end
        checks++; if (clr_id !== 8'd0) begin errors++; $display("FAIL reset_clr_id: got %0d expected 0", clr_id); end
    endtask

    task automatic test_single();
        int cyc; bit got;
        do_reset();
        set_src(37, 8'd5, 1'b0);
        wait_offer(17, cyc, got);
        checks++; if (!got) begin errors++; $display("FAIL single_offer: no offer within %0d cycles, expected within 17", cyc); end
        checks++; if (irq_id !== 8'd37) begin errors++; $display("FAIL single_id: got %0d expected 37", irq_id); end
        checks++; if (irq_lvl !== 8'd5) begin errors++; $display("FAIL single_lvl: got %0d expected 5", irq_lvl); end
        irq_ready = 1'b1;
        ip[37] = 1'b0;
        step();
        irq_ready = 1'b0;
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL single_claim_valid: got %b expected 0", irq_valid); end
        checks++; if (clr_valid !== 1'b0) begin errors++; $display("FAIL single_no_clr: got %b expected 0", clr_valid); end
    endtask

    task automatic test_priority();
        int cyc; bit got;
        do_reset();
        set_src(3, 8'd7, 1'b0);
        set_src(200, 8'd9, 1'b0);
        set_src(100, 8'd9, 1'b0);
        wait_offer(17, cyc, got);
        checks++; if (!got || irq_id !== 8'd100) begin errors++; $display("FAIL prio_first: got valid=%b id=%0d expected id 100", irq_valid, irq_id); end
        checks++; if (irq_lvl !== 8'd9) begin errors++; $display("FAIL prio_first_lvl: got %0d expected 9", irq_lvl); end
        irq_ready = 1'b1; ip[100] = 1'b0;
        step();
        irq_ready = 1'b0;
        wait_offer(17, cyc, got);
        checks++; if (!got || irq_id !== 8'd200) begin errors++; $display("FAIL prio_second: got valid=%b id=%0d expected id 200", irq_valid, irq_id); end
        checks++; if (cyc != 8) begin errors++; $display("FAIL prio_resweep_latency: got %0d cycles expected 8", cyc); end
        irq_ready = 1'b1; ip[200] = 1'b0;
        step();
        irq_ready = 1'b0;
        wait_offer(17, cyc, got);
        checks++; if (!got || irq_id !== 8'd3 || irq_lvl !== 8'd7) begin errors++; $display("FAIL prio_third: got valid=%b id=%0d lvl=%0d expected id 3 lvl 7", irq_valid, irq_id, irq_lvl); end
        irq_ready = 1'b1; ip[3] = 1'b0;
        step();
        irq_ready = 1'b0;
    endtask

    task automatic test_threshold();
        int cyc; bit got; bit saw_clr;
        do_reset();
        set_src(10, 8'd4, 1'b1);
        thresh = 8'd4;
        irq_ready = 1'b1;
        saw_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (clr_valid === 1'b1) saw_clr = 1'b1;
        end
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL thresh_equal: got valid %b expected 0", irq_valid); end
        checks++; if (saw_clr) begin errors++; $display("FAIL ready_idle_clr: got clr pulse expected none"); end
        irq_ready = 1'b0;
        thresh = 8'd3;
        wait_offer(17, cyc, got);
        checks++; if (!got || irq_id !== 8'd10) begin errors++; $display("FAIL thresh_below: got valid=%b id=%0d expected id 10", irq_valid, irq_id); end
        thresh = 8'd4;
        step();
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL thresh_retract: got valid %b expected 0", irq_valid); end
        checks++; if (clr_valid !== 1'b0) begin errors++; $display("FAIL thresh_retract_clr: got %b expected 0", clr_valid); end
        ip[10] = 1'b0;
        thresh = 8'd0;
        set_src(11, 8'd0, 1'b0);
        wait_offer(20, cyc, got);
        checks++; if (got) begin errors++; $display("FAIL lvl0_thresh0: got offer id=%0d expected none", irq_id); end
    endtask

    task automatic test_edge_clear();
        int cyc; bit got;
        do_reset();
        set_src(64, 8'd2, 1'b1);
        wait_offer(17, cyc, got);
        checks++; if (!got || irq_id !== 8'd64) begin errors++; $display("FAIL edge_offer: got valid=%b id=%0d expected id 64", irq_valid, irq_id); end
        irq_ready = 1'b1;
        step();
        irq_ready = 1'b0;
        checks++; if (clr_valid !== 1'b1 || clr_id !== 8'd64) begin errors++; $display("FAIL edge_clr_pulse: got valid=%b id=%0d expected 1/64", clr_valid, clr_id); end
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL edge_claim_valid: got %b expected 0", irq_valid); end
        ip[64] = 1'b0;
        step();
        checks++; if (clr_valid !== 1'b0) begin errors++; $display("FAIL edge_clr_width: got %b expected 0", clr_valid); end
    endtask

    task automatic test_stability();
        int cyc; bit got; bit moved;
        do_reset();
        set_src(20, 8'd3, 1'b0);
        wait_offer(17, cyc, got);
        checks++; if (!got || irq_id !== 8'd20) begin errors++; $display("FAIL stab_offer: got valid=%b id=%0d expected id 20", irq_valid, irq_id); end
        set_src(5, 8'd9, 1'b0);
        moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (irq_valid !== 1'b1 || irq_id !== 8'd20 || irq_lvl !== 8'd3) moved = 1'b1;
        end
        checks++; if (moved) begin errors++; $display("FAIL stab_hold: got valid=%b id=%0d expected stable id 20", irq_valid, irq_id); end
        ie[20] = 1'b0;
        step();
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL stab_retract: got valid %b expected 0", irq_valid); end
        wait_offer(17, cyc, got);
        checks++; if (!got || irq_id !== 8'd5 || irq_lvl !== 8'd9) begin errors++; $display("FAIL stab_next: got valid=%b id=%0d lvl=%0d expected id 5 lvl 9", irq_valid, irq_id, irq_lvl); end
        irq_ready = 1'b1; ip[5] = 1'b0; ie[20] = 1'b1; ip[20] = 1'b0;
        step();
        irq_ready = 1'b0;
    endtask

    task automatic test_reset_hold();
        int cyc; bit got;
        do_reset();
        set_src(37, 8'd5, 1'b1);
        wait_offer(17, cyc, got);
        checks++; if (!got || irq_id !== 8'd37) begin errors++; $display("FAIL rsth_offer: got valid=%b id=%0d expected id 37", irq_valid, irq_id); end
        rst = 1'b1;
        #1;
        checks++; if (irq_valid !== 1'b0 || irq_id !== 8'd0 || irq_lvl !== 8'd0) begin errors++; $display("FAIL rsth_async: got valid=%b id=%0d lvl=%0d expected 0/0/0", irq_valid, irq_id, irq_lvl); end
        irq_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (clr_valid !== 1'b0 || clr_id !== 8'd0) begin errors++; $display("FAIL rsth_no_clr: got valid=%b id=%0d expected 0/0", clr_valid, clr_id); end
        irq_ready = 1'b0;
        rst = 1'b0;
        wait_offer(17, cyc, got);
        checks++; if (!got || irq_id !== 8'd37 || cyc != 8) begin errors++; $display("FAIL rsth_reoffer: got valid=%b id=%0d after %0d cycles expected id 37 after 8", irq_valid, irq_id, cyc); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_threshold();
        test_edge_clear();
        test_stability();
        test_reset_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
